memory_data_arbiter: RTL and testbench
======================================

# memory_data_arbiter

Two-port arbiter and sequencer in front of the data memory (64-bit words, 32 entries, 5-bit address, combinational read, write on `clk` rising edge when `We` is high). It accepts load/store requests from two requesters over valid/ready handshakes. It serialises them into single-cycle memory accesses and returns one response per request. Port 0 is the core load/store unit; port 1 is the debug/loader path that preloads data memory.

## Interface
- `BITS`, 64, data word width; must match the memory.
- `ABITS`, 5, address width; fixed by the memory's `endr` port.
- `clk` input 1 — single clock, all state on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `req_valid` input 2 — per-port request valid; bit i = port i.
- `req_ready` output 2 — per-port request accepted this cycle.
- `req_we` input 2 — per-port write flag; 1 = store, 0 = load.
- `req_endr` input 2*ABITS — per-port address; port i at [i*ABITS +: ABITS].
- `req_din` input 2*BITS — per-port store data; port i at [i*BITS +: BITS].
- `rsp_valid` output 2 — per-port response valid.
- `rsp_ready` input 2 — per-port response accepted.
- `rsp_dout` output BITS — response data, shared; meaningful for the port whose `rsp_valid` is high.
- `mem_endr` output ABITS — memory address.
- `mem_We` output 1 — memory write enable.
- `mem_din` output BITS — memory write data.
- `mem_dout` input BITS — memory combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE:
  - If any `req_valid`, pick a winner and raise `req_ready` for the winner only.
  - Latch winner id, `we`, `endr` and `din` into registers, then go to ACCESS.
  - `req_ready` is combinational from `req_valid` and the arbitration state; it is high only in IDLE.
- ACCESS (exactly one cycle):
  - `mem_endr` and `mem_din` come from the latched registers.
  - `mem_We` = latched `we` AND NOT `rst`.
  - On the closing edge, `rsp_dout` register ← `mem_dout`. For stores this is the pre-write contents.
  - Go to RESP.
- RESP:
  - `rsp_valid[winner]` is high and `rsp_dout` is stable.
  - Stay in RESP until `rsp_ready[winner]`, then go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Outside ACCESS: `mem_We` = 0, and `mem_endr`/`mem_din` hold their last latched values.
- Arbitration with both ports valid in IDLE: the winner is chosen per the Configuration section.
- Winner registers and `last_grant` update only on the accept handshake.
- Responses are strictly in order; at most one transaction is in flight.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_dout` = 0, `mem_We` = 0.
  - `mem_endr` = 0, `mem_din` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
- Latency: request accepted at edge N, memory access during cycle N+1, `rsp_valid` high from cycle N+2.
- Best-case throughput: one transaction per 3 cycles.
- Back-to-back response (`rsp_ready` held high): the next accept is in the cycle after the response handshake.
- Reset mid-operation:
  - Asserting `rst` in ACCESS suppresses `mem_We` in that same cycle, so no write lands.
  - All states, responses and latches clear on that edge; the in-flight transaction is dropped without a response.
- A requester may drop `req_valid` before acceptance; no accept occurs for that port.

## Configuration
- `MEMARB_RR_EN` defined: round-robin on ties.
  - The port not equal to `last_grant` wins.
  - `last_grant` updates on every accept.
- `MEMARB_RR_EN` undefined: fixed priority, port 0 always wins ties.
  - `last_grant` is not implemented.
- Single-requester behaviour is identical in both builds.

## Structure
- Shared package `memory_arb_pkg`:
  - State encoding constants IDLE/ACCESS/RESP.
  - Port count constant 2.
  - Default `BITS`/`ABITS`.
- One sub-module `memory_arb_picker`: combinational winner select from `req_valid` and `last_grant`, containing the `MEMARB_RR_EN` ifdef.
- FSM and latches live in `memory_data_arbiter`.

## Test plan
- Reset, then port 0 loads addr 0 with `rsp_ready`=1 → `req_ready[0]` in cycle 0, `rsp_valid[0]` in cycle 2, `rsp_dout`=51; `mem_We` never high.
- Port 1 stores 0xDEAD_BEEF to addr 2, then port 0 loads addr 2:
  - store response `rsp_dout`=94 (old value);
  - load response `rsp_dout`=0xDEAD_BEEF.
- Both ports hold valid loads for addr 5 with `MEMARB_RR_EN` defined → grants alternate 0,1,0,1; every response `rsp_dout`=18. Without the macro → port 0 granted every time and port 1 starves.
- Hold `rsp_ready[0]`=0 for 4 cycles in RESP → `rsp_valid[0]` and `rsp_dout` stable, `req_ready`=00 throughout, even with `req_valid[1]`=1.
- Assert `rst` during the ACCESS cycle of a store of 7 to addr 5 → `mem_We` stays 0, addr 5 still reads 18 afterwards, and no `rsp_valid` is seen.

Source files
------------

// File: rtl/memory_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding, port count
// and default word/address widths.
package memory_arb_pkg;

   localparam int NPORTS    = 2;
   localparam int DEF_BITS  = 64;
   localparam int DEF_ABITS = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/memory_arb_picker.sv
// Combinational winner select between the two requesters.
// MEMARB_RR_EN defined: round-robin on ties; undefined: port 0 always wins ties.
module memory_arb_picker
   import memory_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req_valid,
`ifdef MEMARB_RR_EN
   input  logic              last_grant,
`endif
   output logic              any_valid,
   output logic              win_id
);

   always_comb begin
      any_valid = |req_valid;
      win_id    = 1'b0;
      if (req_valid == 2'b10) begin
         win_id = 1'b1;
      end else if (req_valid == 2'b11) begin
`ifdef MEMARB_RR_EN
         // On a tie, hand the grant to the port that did not win last time.
         win_id = ~last_grant;
`else
         win_id = 1'b0;
`endif
      end
   end

endmodule

// File: rtl/memory_data_arbiter.sv
// Two-port load/store arbiter and sequencer in front of the 32x64 data memory.
// Optional round-robin tie-breaking is enabled by defining MEMARB_RR_EN.
module memory_data_arbiter
   import memory_arb_pkg::*;
#(
   parameter int BITS  = DEF_BITS,
   parameter int ABITS = DEF_ABITS
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORTS-1:0]       req_valid,
   output logic [NPORTS-1:0]       req_ready,
   input  logic [NPORTS-1:0]       req_we,
   input  logic [NPORTS*ABITS-1:0] req_endr,
   input  logic [NPORTS*BITS-1:0]  req_din,
   output logic [NPORTS-1:0]       rsp_valid,
   input  logic [NPORTS-1:0]       rsp_ready,
   output logic [BITS-1:0]         rsp_dout,
   output logic [ABITS-1:0]        mem_endr,
   output logic                    mem_We,
   output logic [BITS-1:0]         mem_din,
   input  logic [BITS-1:0]         mem_dout
);

   arb_state_e       state_q, state_d;
   logic             win_q;
   logic             we_q;
   logic [ABITS-1:0] endr_q;
   logic [BITS-1:0]  din_q;
   logic [BITS-1:0]  rsp_dout_q;
   logic             any_valid;
   logic             pick_id;
   logic             accept;

   logic [ABITS-1:0] endr_arr [NPORTS];
   logic [BITS-1:0]  din_arr  [NPORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NPORTS; gi++) begin : g_unpack
         assign endr_arr[gi] = req_endr[gi*ABITS +: ABITS];
         assign din_arr[gi]  = req_din[gi*BITS +: BITS];
      end
   endgenerate

`ifdef MEMARB_RR_EN
   logic last_grant_q;

   memory_arb_picker u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .any_valid  (any_valid),
      .win_id     (pick_id)
   );
`else
   memory_arb_picker u_picker (
      .req_valid  (req_valid),
      .any_valid  (any_valid),
      .win_id     (pick_id)
   );
`endif

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      mem_We    = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            // Reset dominates: never advertise an accept that the edge would discard.
            if (any_valid && !rst) begin
               accept             = 1'b1;
               req_ready[pick_id] = 1'b1;
               state_d            = ACCESS;
            end
         end
         ACCESS: begin
            mem_We  = we_q & ~rst;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid[win_q] = 1'b1;
            if (rsp_ready[win_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         win_q      <= 1'b0;
         we_q       <= 1'b0;
         endr_q     <= '0;
         din_q      <= '0;
         rsp_dout_q <= '0;
`ifdef MEMARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            win_q  <= pick_id;
            we_q   <= req_we[pick_id];
            endr_q <= endr_arr[pick_id];
            din_q  <= din_arr[pick_id];
`ifdef MEMARB_RR_EN
            last_grant_q <= pick_id;
`endif
         end
         // Capture read data before the write lands, so stores return the old word.
         if (state_q == ACCESS) begin
            rsp_dout_q <= mem_dout;
         end
      end
   end

   assign rsp_dout = rsp_dout_q;
   assign mem_endr = endr_q;
   assign mem_din  = din_q;

endmodule

// File: tb/tb_memory_data_arbiter.sv
// Directed bench for memory_data_arbiter with a behavioural 32x64 data memory.
module tb_memory_data_arbiter;

   logic         clk;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [1:0]   req_we;
   logic [9:0]   req_endr;
   logic [127:0] req_din;
   logic [1:0]   rsp_valid;
   logic [1:0]   rsp_ready;
   logic [63:0]  rsp_dout;
   logic [4:0]   mem_endr;
   logic         mem_We;
   logic [63:0]  mem_din;
   logic [63:0]  mem_dout;

   logic [63:0]  mem [32];
   logic         mem_init;
   int           we_count;
   int           n_cmp;
   int           n_bad;

   memory_data_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_endr  (req_endr),
      .req_din   (req_din),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dout  (rsp_dout),
      .mem_endr  (mem_endr),
      .mem_We    (mem_We),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_dout = mem[mem_endr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 64'h1000 + 64'(i);
         mem[0] <= 64'd51;
         mem[2] <= 64'd94;
         mem[5] <= 64'd18;
      end else if (mem_We === 1'b1) begin
         mem[mem_endr] <= mem_din;
      end
   end

   always @(posedge clk) begin
      if (mem_We === 1'b1) we_count++;
   end

   task automatic set_port(input int p, input logic we, input logic [4:0] a, input logic [63:0] d);
      req_we[p]           = we;
      req_endr[p*5 +: 5]  = a;
      req_din[p*64 +: 64] = d;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs one transaction with rsp_ready held high; reports timeout instead of checking.
   task automatic run_txn(input int p, input logic we, input logic [4:0] a, input logic [63:0] d,
                          output logic [63:0] dout, output bit to);
      int n;
      to   = 1'b0;
      dout = '0;
      set_port(p, we, a, d);
      req_valid[p] = 1'b1;
      rsp_ready    = 2'b11;
      n = 0;
      #1;
      while (req_ready[p] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
         to = 1'b1;
         req_valid[p] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[p] = 1'b0;
      n = 0;
      #1;
      while (rsp_valid[p] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) to = 1'b1;
      dout = rsp_dout;
      @(negedge clk);
   endtask

   task automatic test_reset();
      req_we   = '0;
      req_endr = '0;
      req_din  = '0;
      mem_init = 1'b1;
      do_reset();
      mem_init = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
      n_cmp++; if (rsp_dout !== 64'd0) begin n_bad++; $display("FAIL reset_rsp_dout: got %h expected 0", rsp_dout); end
      n_cmp++; if (mem_We !== 1'b0) begin n_bad++; $display("FAIL reset_mem_We: got %b expected 0", mem_We); end
      n_cmp++; if (mem_endr !== 5'd0 || mem_din !== 64'd0) begin n_bad++; $display("FAIL reset_mem_bus: got endr %h din %h expected 0 0", mem_endr, mem_din); end
      $display("txn reset: req_ready=%b rsp_valid=%b rsp_dout=%h", req_ready, rsp_valid, rsp_dout);
   endtask

   task automatic test_load_latency();
      int wc;
      wc = we_count;
      set_port(0, 1'b0, 5'd0, 64'd0);
      rsp_ready = 2'b11;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL load_c0_ready: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n_cmp++; if (rsp_valid !== 2'b00 || mem_endr !== 5'd0 || mem_We !== 1'b0)
         begin n_bad++; $display("FAIL load_c1_access: got rsp_valid %b endr %h We %b expected 00 00 0", rsp_valid, mem_endr, mem_We); end
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL load_c2_valid: got %b expected 01", rsp_valid); end
      n_cmp++; if (rsp_dout !== 64'd51) begin n_bad++; $display("FAIL load_c2_dout: got %0d expected 51", rsp_dout); end
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL load_c3_idle: got %b expected 00", rsp_valid); end
      n_cmp++; if (we_count !== wc) begin n_bad++; $display("FAIL load_no_write: got %0d writes expected 0", we_count - wc); end
      $display("txn load p0 addr0: rsp_dout=%0d", rsp_dout);
   endtask

   task automatic test_store_then_load();
      logic [63:0] d;
      bit          to;
      int          wc;
      wc = we_count;
      run_txn(1, 1'b1, 5'd2, 64'hDEAD_BEEF, d, to);
      n_cmp++; if (to || d !== 64'd94) begin n_bad++; $display("FAIL store_old_value: got %0d timeout %0d expected 94", d, to); end
      n_cmp++; if (we_count !== wc + 1) begin n_bad++; $display("FAIL store_one_write: got %0d expected 1", we_count - wc); end
      $display("txn store p1 addr2 <= deadbeef: rsp_dout=%0d", d);
      run_txn(0, 1'b0, 5'd2, 64'd0, d, to);
      n_cmp++; if (to || d !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL load_new_value: got %h timeout %0d expected deadbeef", d, to); end
      n_cmp++; if (mem_endr !== 5'd2 || mem_We !== 1'b0) begin n_bad++; $display("FAIL hold_mem_bus: got endr %h We %b expected 02 0", mem_endr, mem_We); end
      $display("txn load p0 addr2: rsp_dout=%h", d);
   endtask

   task automatic test_arbitration();
      logic [1:0] exp;
      do_reset();
      set_port(0, 1'b0, 5'd5, 64'd0);
      set_port(1, 1'b0, 5'd5, 64'd0);
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int r = 0; r < 4; r++) begin
`ifdef MEMARB_RR_EN
         exp = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp = 2'b01;
`endif
         #1;
         n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL arb_grant_%0d: got %b expected %b", r, req_ready, exp); end
         @(negedge clk);
         @(negedge clk); #1;
         n_cmp++; if (rsp_valid !== exp || rsp_dout !== 64'd18)
            begin n_bad++; $display("FAIL arb_rsp_%0d: got valid %b dout %0d expected %b 18", r, rsp_valid, rsp_dout, exp); end
         $display("txn tie round %0d: grant=%b rsp_dout=%0d", r, exp, rsp_dout);
         @(negedge clk);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_back_to_back();
      set_port(0, 1'b0, 5'd0, 64'd0);
      set_port(1, 1'b0, 5'd0, 64'd0);
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_accept: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b10;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (rsp_valid !== 2'b01 || rsp_dout !== 64'd51 || req_ready !== 2'b00)
            begin n_bad++; $display("FAIL bp_hold_%0d: got valid %b dout %0d ready %b expected 01 51 00", i, rsp_valid, rsp_dout, req_ready); end
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_no_accept_on_rsp: got %b expected 00", req_ready); end
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== 2'b10 || rsp_valid !== 2'b00)
         begin n_bad++; $display("FAIL bp_next_accept: got ready %b valid %b expected 10 00", req_ready, rsp_valid); end
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 2'b10;
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 2'b10 || rsp_dout !== 64'd51)
         begin n_bad++; $display("FAIL bp_p1_rsp: got valid %b dout %0d expected 10 51", rsp_valid, rsp_dout); end
      $display("txn backpressure p0 then p1 load addr0: rsp_dout=%0d", rsp_dout);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      logic [63:0] d;
      bit          to;
      int          wc;
      wc = we_count;
      set_port(0, 1'b1, 5'd5, 64'd7);
      rsp_ready = 2'b11;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmid_accept: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      rst = 1'b1;
      #1;
      n_cmp++; if (mem_We !== 1'b0) begin n_bad++; $display("FAIL rstmid_we_suppressed: got %b expected 0", mem_We); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rstmid_no_rsp_%0d: got %b expected 00", i, rsp_valid); end
         @(negedge clk);
      end
      n_cmp++; if (we_count !== wc || mem[5] !== 64'd18)
         begin n_bad++; $display("FAIL rstmid_no_write: got writes %0d mem5 %0d expected 0 18", we_count - wc, mem[5]); end
      run_txn(0, 1'b0, 5'd5, 64'd0, d, to);
      n_cmp++; if (to || d !== 64'd18) begin n_bad++; $display("FAIL rstmid_readback: got %0d timeout %0d expected 18", d, to); end
      $display("txn reset during store access, readback addr5: rsp_dout=%0d", d);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      we_count  = 0;
      rst       = 1'b1;
      mem_init  = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      test_reset();
      test_load_latency();
      test_store_then_load();
      test_arbitration();
      test_back_to_back();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
